// File: rtl/dram_arbiter_if.sv
// Bundle of the core, DMA and dRam-side signals around the dRam arbiter.
// The slave modport is the arbiter's view; master is the requesters-plus-memory view.
interface dram_arbiter_if #(
  parameter int ADDR_W = 19,
  parameter int DATA_W = 8
);
  // core port
  logic              c_req;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              c_gnt;
  logic              c_rvalid;
  logic [DATA_W-1:0] c_rdata;
  logic              c_err;
  // DMA port
  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_lock;
  logic              d_gnt;
  logic              d_rvalid;
  logic [DATA_W-1:0] d_rdata;
  logic              d_err;
  // dRam side
  logic [ADDR_W-1:0] dAddr;
  logic [DATA_W-1:0] d_in;
  logic [1:0]        MEM_WRITE;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  c_req, c_we, c_addr, c_wdata,
    input  d_req, d_we, d_addr, d_wdata, d_lock,
    input  mem_rdata,
    output c_gnt, c_rvalid, c_rdata, c_err,
    output d_gnt, d_rvalid, d_rdata, d_err,
    output dAddr, d_in, MEM_WRITE
  );

  modport master (
    output c_req, c_we, c_addr, c_wdata,
    output d_req, d_we, d_addr, d_wdata, d_lock,
    output mem_rdata,
    input  c_gnt, c_rvalid, c_rdata, c_err,
    input  d_gnt, d_rvalid, d_rdata, d_err,
    input  dAddr, d_in, MEM_WRITE
  );
endinterface

// File: rtl/dram_arbiter.sv
// Round-robin core/DMA arbiter for the single-port dRam, with DMA burst lock and range check.
// Define DRAM_ARB_PERF_EN to add saturating grant/wait performance counters.
module dram_arbiter #(
  parameter int ADDR_W   = 19,
  parameter int DATA_W   = 8,
  parameter int ADDR_MAX = 262144,
  parameter int MAX_LOCK = 64
) (
  input  logic          clk,
  input  logic          rst_n,
  dram_arbiter_if.slave bus
`ifdef DRAM_ARB_PERF_EN
  ,
  output logic [15:0]   c_grant_cnt,
  output logic [15:0]   d_grant_cnt,
  output logic [15:0]   c_wait_cnt
`endif
);

  localparam int                CNT_W      = $clog2(MAX_LOCK + 1);
  localparam logic [ADDR_W-1:0] ADDR_LIMIT = ADDR_W'(ADDR_MAX);

  typedef enum logic {ARB, LOCK} state_t;

  state_t             state_q, state_d;
  logic               last_dma_q, last_dma_d;
  logic [CNT_W-1:0]   lock_cnt_q, lock_cnt_d;
  logic               gnt_c, gnt_d;
  logic               locked_now;

  logic               granted;
  logic               sel_we;
  logic [ADDR_W-1:0]  sel_addr;
  logic [DATA_W-1:0]  sel_wdata;
  logic               out_of_range;

  logic [ADDR_W-1:0]  addr_q;
  logic [DATA_W-1:0]  wdata_q;
  logic               c_rv_q, c_err_q, d_rv_q, d_err_q;

  assign locked_now = (state_q == LOCK) && bus.d_req && bus.d_lock;

  always_comb begin
    // NOTE: every signal gets a default first so no path can leave one unassigned and infer a latch.
    state_d    = ARB;
    last_dma_d = last_dma_q;
    lock_cnt_d = '0;
    gnt_c      = 1'b0;
    gnt_d      = 1'b0;

    if (locked_now) begin
      gnt_d = 1'b1;
    end else if (bus.c_req && bus.d_req) begin
      gnt_c = last_dma_q;
      gnt_d = !last_dma_q;
    end else begin
      gnt_c = bus.c_req;
      gnt_d = bus.d_req;
    end

    if (gnt_c) last_dma_d = 1'b0;
    if (gnt_d) last_dma_d = 1'b1;

    // A locked run ends on the grant that reaches MAX_LOCK; last winner is then DMA so the core goes next.
    if (gnt_d && bus.d_lock) begin
      lock_cnt_d = locked_now ? lock_cnt_q + 1'b1 : CNT_W'(1);
      if (lock_cnt_d == CNT_W'(MAX_LOCK)) lock_cnt_d = '0;
      else                                state_d    = LOCK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ARB;
      last_dma_q <= 1'b1;
      lock_cnt_q <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the pre-edge values.
      state_q    <= state_d;
      last_dma_q <= last_dma_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end

  assign granted      = gnt_c | gnt_d;
  assign sel_we       = gnt_d ? bus.d_we    : bus.c_we;
  assign sel_addr     = gnt_d ? bus.d_addr  : bus.c_addr;
  assign sel_wdata    = gnt_d ? bus.d_wdata : bus.c_wdata;
  assign out_of_range = sel_addr > ADDR_LIMIT;

  assign bus.c_gnt     = gnt_c;
  assign bus.d_gnt     = gnt_d;
  assign bus.dAddr     = granted ? sel_addr  : addr_q;
  assign bus.d_in      = granted ? sel_wdata : wdata_q;
  assign bus.MEM_WRITE = (granted && sel_we && !out_of_range) ? 2'b10 : 2'b00;

  // Response tags: reads and every rejected access answer one cycle after the grant.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
      c_rv_q  <= 1'b0;
      c_err_q <= 1'b0;
      d_rv_q  <= 1'b0;
      d_err_q <= 1'b0;
    end else begin
      if (granted) begin
        addr_q  <= sel_addr;
        wdata_q <= sel_wdata;
      end
      c_rv_q  <= gnt_c && (!sel_we || out_of_range);
      c_err_q <= gnt_c && out_of_range;
      d_rv_q  <= gnt_d && (!sel_we || out_of_range);
      d_err_q <= gnt_d && out_of_range;
    end
  end

  assign bus.c_rvalid = c_rv_q;
  assign bus.c_err    = c_err_q;
  assign bus.c_rdata  = (c_rv_q && !c_err_q) ? bus.mem_rdata : '0;
  assign bus.d_rvalid = d_rv_q;
  assign bus.d_err    = d_err_q;
  assign bus.d_rdata  = (d_rv_q && !d_err_q) ? bus.mem_rdata : '0;

`ifdef DRAM_ARB_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c_grant_cnt <= '0;
      d_grant_cnt <= '0;
      c_wait_cnt  <= '0;
    end else begin
      if (gnt_c && c_grant_cnt != 16'hFFFF) c_grant_cnt <= c_grant_cnt + 16'd1;
      if (gnt_d && d_grant_cnt != 16'hFFFF) d_grant_cnt <= d_grant_cnt + 16'd1;
      if (bus.c_req && !gnt_c && c_wait_cnt != 16'hFFFF) c_wait_cnt <= c_wait_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_dram_arbiter.sv
// Bench for dram_arbiter: directed scenarios plus randomized traffic against a rule-level model.
// Build with DRAM_ARB_PERF_EN defined to also exercise the performance counters.
module tb_dram_arbiter;
  localparam int ADDR_W   = 19;
  localparam int DATA_W   = 8;
  localparam int ADDR_MAX = 262144;
  localparam int MAX_LOCK = 64;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dram_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef DRAM_ARB_PERF_EN
  logic [15:0] c_grant_cnt, d_grant_cnt, c_wait_cnt;
`endif

  dram_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ADDR_MAX(ADDR_MAX), .MAX_LOCK(MAX_LOCK)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .bus(bus)
`ifdef DRAM_ARB_PERF_EN
    ,
    .c_grant_cnt(c_grant_cnt),
    .d_grant_cnt(d_grant_cnt),
    .c_wait_cnt(c_wait_cnt)
`endif
  );

  // dRam stand-in: registered read, write on MEM_WRITE == 2'b10, unwritten bytes read as zero.
  logic [7:0] mem [0:(1<<ADDR_W)-1];
  bit         vld [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (bus.MEM_WRITE == 2'b10) begin
      mem[bus.dAddr] <= bus.d_in;
      vld[bus.dAddr] <= 1'b1;
    end
    bus.mem_rdata <= vld[bus.dAddr] ? mem[bus.dAddr] : 8'h00;
  end

  int vectors = 0;
  int miscompares = 0;

  // Reference model state: rule-level view of arbitration and memory contents.
  logic [7:0]  ref_mem [int];
  bit          m_last_dma;
  int          m_run;
  logic [31:0] hold_addr, hold_wdata;
  logic [31:0] e_c_rv, e_c_err, e_c_rdata, e_d_rv, e_d_err, e_d_rdata;
  logic        last_c_gnt, last_d_gnt;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.c_req = 0; bus.c_we = 0; bus.c_addr = '0; bus.c_wdata = '0;
    bus.d_req = 0; bus.d_we = 0; bus.d_addr = '0; bus.d_wdata = '0; bus.d_lock = 0;
  endtask

  task automatic check_outputs_reset(input string tag);
    check({tag, "_c_gnt"},    32'(bus.c_gnt), 0);
    check({tag, "_d_gnt"},    32'(bus.d_gnt), 0);
    check({tag, "_c_rvalid"}, 32'(bus.c_rvalid), 0);
    check({tag, "_d_rvalid"}, 32'(bus.d_rvalid), 0);
    check({tag, "_c_err"},    32'(bus.c_err), 0);
    check({tag, "_d_err"},    32'(bus.d_err), 0);
    check({tag, "_c_rdata"},  32'(bus.c_rdata), 0);
    check({tag, "_d_rdata"},  32'(bus.d_rdata), 0);
    check({tag, "_dAddr"},    32'(bus.dAddr), 0);
    check({tag, "_d_in"},     32'(bus.d_in), 0);
    check({tag, "_MEM_WRITE"}, 32'(bus.MEM_WRITE), 0);
  endtask

  // Asserts reset (callable mid-cycle), checks reset values and returns at a negedge with reset released.
  task automatic do_reset();
    rst_n = 0;
    idle();
    @(posedge clk);
    #1;
    check_outputs_reset("rst");
    m_last_dma = 1; m_run = 0;
    hold_addr = 0; hold_wdata = 0;
    e_c_rv = 0; e_c_err = 0; e_c_rdata = 0;
    e_d_rv = 0; e_d_err = 0; e_d_rdata = 0;
    @(negedge clk);
    rst_n = 1;
  endtask

  // One clock: inputs already applied at the negedge; check and advance the model, return at next negedge.
  task automatic step();
    logic        gc, gd, lock_path, we, oor, acc;
    logic [31:0] a, wd, rd;
    #1;
    check("c_rvalid", 32'(bus.c_rvalid), e_c_rv);
    check("c_err",    32'(bus.c_err),    e_c_err);
    check("c_rdata",  32'(bus.c_rdata),  e_c_rdata);
    check("d_rvalid", 32'(bus.d_rvalid), e_d_rv);
    check("d_err",    32'(bus.d_err),    e_d_err);
    check("d_rdata",  32'(bus.d_rdata),  e_d_rdata);

    lock_path = (m_run > 0) && bus.d_req && bus.d_lock;
    gc = 0; gd = 0;
    if (lock_path)                    gd = 1;
    else if (bus.c_req && bus.d_req) begin gc = m_last_dma; gd = !m_last_dma; end
    else begin gc = bus.c_req; gd = bus.d_req; end
    check("c_gnt", 32'(bus.c_gnt), 32'(gc));
    check("d_gnt", 32'(bus.d_gnt), 32'(gd));
    last_c_gnt = bus.c_gnt;
    last_d_gnt = bus.d_gnt;

    we  = gd ? bus.d_we : bus.c_we;
    a   = gd ? 32'(bus.d_addr) : 32'(bus.c_addr);
    wd  = gd ? 32'(bus.d_wdata) : 32'(bus.c_wdata);
    oor = int'(a) > ADDR_MAX;
    acc = gc || gd;
    if (acc) begin hold_addr = a; hold_wdata = wd; end
    check("dAddr",     32'(bus.dAddr), hold_addr);
    check("d_in",      32'(bus.d_in),  hold_wdata);
    check("MEM_WRITE", 32'(bus.MEM_WRITE), (acc && we && !oor) ? 32'd2 : 32'd0);

    rd = ref_mem.exists(int'(a)) ? 32'(ref_mem[int'(a)]) : 32'd0;
    if (acc && we && !oor) ref_mem[int'(a)] = wd[7:0];
    e_c_rv = 32'(gc && (!we || oor));  e_c_err = 32'(gc && oor);
    e_c_rdata = (gc && !we && !oor) ? rd : 32'd0;
    e_d_rv = 32'(gd && (!we || oor));  e_d_err = 32'(gd && oor);
    e_d_rdata = (gd && !we && !oor) ? rd : 32'd0;

    if (gc) m_last_dma = 0;
    if (gd) m_last_dma = 1;
    if (gd && bus.d_lock) begin
      m_run = lock_path ? m_run + 1 : 1;
      if (m_run == MAX_LOCK) m_run = 0;
    end else begin
      m_run = 0;
    end
    @(negedge clk);
  endtask

  function automatic logic [ADDR_W-1:0] rand_addr();
    if ($urandom_range(0, 7) == 0) return 19'h40000 + 19'($urandom_range(0, 2));
    return 19'h100 + 19'($urandom_range(0, 15));
  endfunction

  int dma_grants, dma_before_core, core_at;

  initial begin
    rst_n = 0;
    idle();
    last_c_gnt = 0; last_d_gnt = 0;
    do_reset();

    // Core write 0x1234 <- 0xA5, then read it back.
    bus.c_req = 1; bus.c_we = 1; bus.c_addr = 19'h1234; bus.c_wdata = 8'hA5;
    step();
    check("t2_wr_gnt", 32'(last_c_gnt), 1);
    bus.c_we = 0;
    step();
    check("t2_rd_gnt", 32'(last_c_gnt), 1);
    check("t2_rvalid", 32'(bus.c_rvalid), 1);
    check("t2_rdata",  32'(bus.c_rdata), 32'hA5);
    idle();
    step();

    // Reset asserted while a read is in flight: its response must vanish.
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 19'h1234;
    #1;
    check("t1_gnt", 32'(bus.c_gnt), 1);
    do_reset();
    step();
    check("t1_no_rvalid", 32'(bus.c_rvalid), 0);

    // Both ports request every cycle without lock: strict alternation starting with the core.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      bus.c_req = 1; bus.c_we = 0; bus.c_addr = rand_addr();
      bus.d_req = 1; bus.d_we = 0; bus.d_addr = rand_addr(); bus.d_lock = 0;
      step();
      check("t3_c_alt", 32'(last_c_gnt), 32'(i % 2 == 0));
      check("t3_d_alt", 32'(last_d_gnt), 32'(i % 2 == 1));
    end

    // Locked DMA burst of 100 with the core waiting: 64 DMA grants, then one core grant.
    do_reset();
    dma_grants = 0; dma_before_core = 0; core_at = -1;
    for (int i = 0; i < 300 && dma_grants < 100; i++) begin
      bus.d_req = 1; bus.d_lock = 1; bus.d_we = $urandom_range(0, 1) == 1;
      bus.d_addr = rand_addr(); bus.d_wdata = 8'($urandom);
      bus.c_req = (i > 0); bus.c_we = 0; bus.c_addr = rand_addr();
      step();
      if (last_d_gnt) begin
        dma_grants++;
        if (core_at < 0) dma_before_core++;
      end
      if (last_c_gnt && core_at < 0) core_at = i;
    end
    check("t4_dma_burst", 32'(dma_before_core), 64);
    check("t4_core_slot", 32'(core_at), 64);
    check("t4_dma_total", 32'(dma_grants), 100);
    idle();
    step();

    // Range check at the ADDR_MAX boundary.
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 19'h40001;
    step();
    check("t5_oor_rvalid", 32'(bus.c_rvalid), 1);
    check("t5_oor_err",    32'(bus.c_err), 1);
    check("t5_oor_rdata",  32'(bus.c_rdata), 0);
    bus.c_we = 1; bus.c_addr = 19'h40000; bus.c_wdata = 8'h5A;
    step();
    check("t5_wr_no_rvalid", 32'(bus.c_rvalid), 0);
    check("t5_wr_err",       32'(bus.c_err), 0);
    bus.c_we = 0;
    step();
    check("t5_rd_rvalid", 32'(bus.c_rvalid), 1);
    check("t5_rd_err",    32'(bus.c_err), 0);
    check("t5_rd_rdata",  32'(bus.c_rdata), 32'h5A);
    bus.c_we = 1; bus.c_addr = 19'h7FFFF; bus.c_wdata = 8'h33;
    step();
    check("t5_oor_wr_rvalid", 32'(bus.c_rvalid), 1);
    check("t5_oor_wr_err",    32'(bus.c_err), 1);
    idle();
    step();

    // Randomized traffic: fields held until granted, occasional abandoned requests, sticky lock.
    for (int i = 0; i < 600; i++) begin
      if (last_c_gnt || !bus.c_req) begin
        bus.c_req = $urandom_range(0, 2) != 0;
        bus.c_we = $urandom_range(0, 1) == 1; bus.c_addr = rand_addr(); bus.c_wdata = 8'($urandom);
      end else if ($urandom_range(0, 15) == 0) begin
        bus.c_req = 0;
      end
      if (last_d_gnt || !bus.d_req) begin
        bus.d_req = $urandom_range(0, 2) != 0;
        bus.d_we = $urandom_range(0, 1) == 1; bus.d_addr = rand_addr(); bus.d_wdata = 8'($urandom);
        if ($urandom_range(0, 7) == 0) bus.d_lock = !bus.d_lock;
      end else if ($urandom_range(0, 15) == 0) begin
        bus.d_req = 0;
      end
      step();
    end
    idle();
    step();

`ifdef DRAM_ARB_PERF_EN
    // Five core grants with three wait cycles, then saturation of the grant counter.
    do_reset();
    bus.c_req = 1; bus.c_we = 0; bus.c_addr = 19'h10;
    step();
    step();
    bus.d_req = 1; bus.d_we = 0; bus.d_addr = 19'h20;
    for (int i = 0; i < 6; i++) step();
    check("t6_c_grant_cnt", 32'(c_grant_cnt), 5);
    check("t6_c_wait_cnt",  32'(c_wait_cnt), 3);
    check("t6_d_grant_cnt", 32'(d_grant_cnt), 3);
    bus.d_req = 0;
    repeat (65540) @(negedge clk);
    check("t6_c_grant_sat", 32'(c_grant_cnt), 32'hFFFF);
    check("t6_c_wait_hold", 32'(c_wait_cnt), 3);
    do_reset();
    check("t6_cnt_reset", 32'(c_grant_cnt), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
